mem_handshake_ctrl: RTL and testbench
=====================================

// Module: mem_handshake_ctrl
// PURPOSE
//  Memory controller that sits directly downstream of the control unit. It serves
//  instruction fetches, loads and stores over the Valid/RW/ready handshake.
//  Each request is one 32-bit word, backed by an internal word-addressed RAM.
//  Access latency is configurable. ready drops while a request is in flight and
//  rises when it completes, which is what the control unit's wait(!ready);
//  wait(ready) sequence consumes.
// PARAMETERS
//  ADDR_W   8  word-index width; RAM depth = 2**ADDR_W words
//  LATENCY  2  BUSY cycles per access; legal range 1..15
// PORTS
//  clk    in   1   system clock, rising edge
//  reset  in   1   asynchronous, active-high reset
//  valid  in   1   request strobe from control unit (Valid)
//  rw     in   1   1 = read, 0 = write (RW)
//  addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//  wdata  in   32  store data, sampled at request acceptance
//  rdata  out  32  read data; held until the next read completes
//  ready  out  1   1 = idle/done, 0 = request in progress
//  err    out  1   misaligned access flag (only with MEMCTL_ALIGN_CHECK_EN)
// BEHAVIOUR
//  Reset (async): ready=1, rdata=0, err=0, state=IDLE, latency counter=0.
//   RAM contents are not cleared.
//  States:
//   IDLE:    ready=1. At a posedge with valid=1, latch addr, rw and wdata,
//            load counter=LATENCY, go to BUSY. ready=0 from the next cycle on.
//   BUSY:    ready=0; counter decrements each cycle. At the edge where counter==1:
//            read  -> rdata <= RAM[idx]; write -> RAM[idx] <= wdata_latched.
//            ready=1 from that edge on; go to RELEASE.
//   RELEASE: ready=1. Stay while valid=1; go to IDLE when valid=0. A held valid
//            never re-triggers; each access needs valid to deassert and reassert.
//  Latency: request accepted at edge T -> ready low T+1..T+LATENCY ->
//   ready high and data/commit at edge T+LATENCY.
//  Inputs change during BUSY: ignored; only the latched values are used.
//  valid drops during BUSY: access still completes; RELEASE exits immediately.
//  Address bits above ADDR_W+1 are ignored, so addresses alias modulo 4*2**ADDR_W.
//   addr[1:0] is ignored unless the option below is enabled.
//  Reset mid-BUSY: access aborted, the pending write is NOT committed, ready=1.
//  Read-after-write to the same word returns the new data; there is no bypass hazard.
// CONFIGURATION
//  MEMCTL_ALIGN_CHECK_EN defined:
//   - At acceptance, addr[1:0]!=0 sets err=1.
//   - The access still takes LATENCY cycles. Writes are suppressed; reads return
//     32'hDEAD_BEEF.
//   - err clears at the next accepted aligned request, or on reset.
//  Undefined: err is tied to 0 and addr[1:0] is ignored.
// TESTING
//  1 reset -> ready=1, rdata=0, err=0.
//  2 write addr=0x10, wdata=0xCAFEF00D, then read 0x10 with LATENCY=2
//    -> ready low for exactly 2 cycles per access; rdata=0xCAFEF00D.
//  3 valid held high for 10 cycles after completion -> exactly one access; ready
//    stays 1. Deassert then reassert valid -> a second access starts.
//  4 write addr=0x4 data=0x1 with ADDR_W=8, then read 0x404 -> 0x1 (aliasing).
//  5 reset asserted mid-BUSY of a write of 0x55 to 0x20 -> ready=1 immediately;
//    a later read of 0x20 returns the old value.
//  6 MEMCTL_ALIGN_CHECK_EN: write 0x22 -> err=1, RAM unchanged; read 0x22 ->
//    rdata=0xDEADBEEF; aligned read -> err=0.

Source files
------------

// File: rtl/mem_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// mem_handshake_ctrl
//
// Memory controller that sits directly downstream of the control unit and
// serves instruction fetches, loads and stores over the valid/rw/ready
// handshake. Each request moves one 32-bit word to or from an internal
// word-addressed RAM after a fixed, configurable number of BUSY cycles.
//
// ready drops on the cycle after a request is accepted and rises again on the
// edge that completes it. A valid held high after completion never starts a
// second access: valid must be deasserted before the next request counts.
//
// Parameters
//   ADDR_W   word-index width; RAM depth = 2**ADDR_W words
//   LATENCY  BUSY cycles per access, legal range 1..15
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   valid  in   1   request strobe from the control unit
//   rw     in   1   1 = read, 0 = write
//   addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//   wdata  in   32  store data, captured when the request is accepted
//   rdata  out  32  read data; held until the next read completes
//   ready  out  1   1 = idle/done, 0 = request in progress
//   err    out  1   misaligned access flag
//
// Build option
//   MEMCTL_ALIGN_CHECK_EN  when defined, an accepted request with
//   addr[1:0] != 0 sets err; its write is dropped and its read returns
//   32'hDEAD_BEEF. err clears on the next accepted aligned request. When the
//   macro is undefined, err stays 0 and addr[1:0] is ignored.
// -----------------------------------------------------------------------------
module mem_handshake_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT_C = 4'(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Byte address to word index; upper address bits fall away, so addresses
  // alias modulo 4*DEPTH.
  function automatic logic [ADDR_W-1:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[ADDR_W+1:2];
  endfunction

  state_t              state_r;
  state_t              next_state_s;
  logic                ready_r;
  logic                ready_next_s;
  logic                accept_s;
  logic                done_s;
  logic                write_en_s;
  logic                bad_s;
  logic [3:0]          cnt_r;
  logic [ADDR_W-1:0]   idx_r;
  logic                rw_r;
  logic [31:0]         wdata_r;
  logic [31:0]         rdata_r;
  logic                err_r;
  logic                bad_r;
  logic [31:0]         mem_r [DEPTH];
  logic                unused_s;

`ifdef MEMCTL_ALIGN_CHECK_EN
  assign bad_s = (addr[1:0] != 2'b00);
`else
  assign bad_s = 1'b0;
`endif

  // Address bits outside the word index never reach any logic.
  assign unused_s = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Only a completing, well-formed write touches the RAM. A reset during BUSY
  // forces the state back to IDLE before the completing edge, so the pending
  // write is dropped.
  assign write_en_s = done_s & ~rw_r & ~bad_r;

  assign rdata = rdata_r;
  assign ready = ready_r;
  assign err   = err_r;

  // State and ready register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      ready_r <= ready_next_s;
    end
  end

  // Next-state, next-ready and the accept/complete strobes.
  always_comb begin
    next_state_s = state_r;
    ready_next_s = ready_r;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid) begin
          next_state_s = ST_BUSY;
          ready_next_s = 1'b0;
          accept_s     = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
          ready_next_s = 1'b1;
        end
      end
      ST_BUSY: begin
        // cnt_r == 1 marks the LATENCY-th edge after acceptance.
        if (cnt_r == 4'd1) begin
          next_state_s = ST_RELEASE;
          ready_next_s = 1'b1;
          done_s       = 1'b1;
        end else begin
          next_state_s = ST_BUSY;
          ready_next_s = 1'b0;
        end
      end
      ST_RELEASE: begin
        // Wait for valid to drop so a held strobe cannot start a new access.
        if (valid) begin
          next_state_s = ST_RELEASE;
        end else begin
          next_state_s = ST_IDLE;
        end
        ready_next_s = 1'b1;
      end
      default: begin
        next_state_s = ST_IDLE;
        ready_next_s = 1'b1;
      end
    endcase
  end

  // Request capture, latency counter, read data and error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      rw_r    <= 1'b0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
      bad_r   <= 1'b0;
    end else if (accept_s) begin
      cnt_r   <= LAT_C;
      idx_r   <= word_index(addr);
      rw_r    <= rw;
      wdata_r <= wdata;
      bad_r   <= bad_s;
      err_r   <= bad_s;
    end else if (done_s) begin
      cnt_r <= 4'd0;
      if (rw_r) begin
        rdata_r <= bad_r ? 32'hDEAD_BEEF : mem_r[idx_r];
      end
    end else if (state_r == ST_BUSY) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (write_en_s) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_handshake_ctrl
//
// Directed bench for mem_handshake_ctrl (ADDR_W=8, LATENCY=2). A transaction
// model (array memory plus a countdown of remaining busy cycles) predicts
// ready/rdata/err and is compared against the DUT on every falling edge.
// Hand-computed literals pin latency, read data and reset behaviour.
// Inputs change 2 time units after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_handshake_ctrl;

  localparam int AW  = 8;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int total = 0;
  int bad = 0;
  logic last_ready;

  mem_handshake_ctrl #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .valid(valid), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- transaction model ----------------
  logic [31:0] m_mem [256];
  logic        m_ready = 1'b1;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  int          m_left = 0;
  logic        m_armed = 1'b1;
  logic        t_rw = 1'b0;
  int          t_idx = 0;
  logic [31:0] t_data = 32'd0;
  logic        t_bad = 1'b0;

  function automatic logic misaligned(input logic [31:0] a);
`ifdef MEMCTL_ALIGN_CHECK_EN
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready <= 1'b1; m_rdata <= 32'd0; m_err <= 1'b0;
      m_left <= 0; m_armed <= 1'b1;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_ready <= 1'b1;
        m_armed <= 1'b0;
        if (t_rw) m_rdata <= t_bad ? 32'hDEADBEEF : m_mem[t_idx];
        else if (!t_bad) m_mem[t_idx] <= t_data;
      end
    end else if (!m_armed) begin
      if (!valid) m_armed <= 1'b1;
    end else if (valid) begin
      t_rw <= rw; t_idx <= int'((addr / 4) % 256); t_data <= wdata;
      t_bad <= misaligned(addr); m_err <= misaligned(addr);
      m_left <= LAT; m_ready <= 1'b0;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare DUT to model at the falling edge, then move to 2 units
  // after the next rising edge where inputs may change.
  task automatic step();
    @(negedge clk);
    chk("ready", {31'd0, ready}, {31'd0, m_ready});
    chk("rdata", rdata, m_rdata);
    chk("err", {31'd0, err}, {31'd0, m_err});
    last_ready = ready;
    @(posedge clk);
    #2;
  endtask

  // Full access: raise valid, count ready-low cycles, hold valid for 'hold'
  // extra cycles (counting any ready-low there), then drop valid.
  task automatic do_access(input logic r, input logic [31:0] a, input logic [31:0] d,
                           input int hold, output int low, output int hold_low);
    low = 0; hold_low = 0;
    valid = 1'b1; rw = r; addr = a; wdata = d;
    step();
    for (int i = 0; i < 50; i++) begin
      step();
      if (last_ready) break;
      low++;
    end
    if (!last_ready) chk("ready_timeout", 32'd0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      step();
      if (!last_ready) hold_low++;
    end
    valid = 1'b0;
    step();
  endtask

  int lo, hl;

  initial begin
    // 1: reset state
    @(posedge clk); #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    step();
    reset = 1'b0;
    step();

    // 2: write then read, latency 2 each
    do_access(1'b0, 32'h10, 32'hCAFEF00D, 0, lo, hl);
    chk("wr_low_cycles", lo, 32'd2);
    do_access(1'b1, 32'h10, 32'h0, 0, lo, hl);
    chk("rd_low_cycles", lo, 32'd2);
    chk("rd_data", rdata, 32'hCAFEF00D);

    // 3: held valid gives one access; release and reassert gives another
    do_access(1'b0, 32'h30, 32'h12345678, 10, lo, hl);
    chk("hold_low_cycles", lo, 32'd2);
    chk("hold_no_retrigger", hl, 32'd0);
    do_access(1'b1, 32'h30, 32'h0, 0, lo, hl);
    chk("second_access_low", lo, 32'd2);
    chk("second_access_data", rdata, 32'h12345678);

    // 4: aliasing modulo 4*256 bytes
    do_access(1'b0, 32'h4, 32'h1, 0, lo, hl);
    do_access(1'b1, 32'h404, 32'h0, 0, lo, hl);
    chk("alias_data", rdata, 32'h1);

    // 5: reset mid-BUSY aborts the write
    do_access(1'b0, 32'h20, 32'h11, 0, lo, hl);
    valid = 1'b1; rw = 1'b0; addr = 32'h20; wdata = 32'h55;
    step();
    valid = 1'b0; addr = 32'h0; wdata = 32'h0;
    step();
    reset = 1'b1;
    #1;
    chk("midbusy_reset_ready", {31'd0, ready}, 32'd1);
    step();
    reset = 1'b0;
    step();
    do_access(1'b1, 32'h20, 32'h0, 0, lo, hl);
    chk("abort_old_data", rdata, 32'h11);

    // Inputs changing during BUSY are ignored
    valid = 1'b1; rw = 1'b0; addr = 32'h40; wdata = 32'hA5A5A5A5;
    step();
    rw = 1'b1; addr = 32'h44; wdata = 32'hFFFFFFFF;
    step();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    do_access(1'b1, 32'h40, 32'h0, 0, lo, hl);
    chk("busy_inputs_ignored", rdata, 32'hA5A5A5A5);

`ifdef MEMCTL_ALIGN_CHECK_EN
    // 6: misaligned accesses flagged, write dropped, read poisoned
    do_access(1'b0, 32'h22, 32'h99, 0, lo, hl);
    chk("mis_wr_err", {31'd0, err}, 32'd1);
    chk("mis_wr_low", lo, 32'd2);
    do_access(1'b1, 32'h22, 32'h0, 0, lo, hl);
    chk("mis_rd_data", rdata, 32'hDEADBEEF);
    do_access(1'b1, 32'h20, 32'h0, 0, lo, hl);
    chk("aligned_err_clear", {31'd0, err}, 32'd0);
    chk("mis_ram_unchanged", rdata, 32'h11);
`else
    // addr[1:0] ignored: 0x51 lands in word 0x50, no error
    do_access(1'b0, 32'h51, 32'h77, 0, lo, hl);
    chk("low_bits_err", {31'd0, err}, 32'd0);
    do_access(1'b1, 32'h50, 32'h0, 0, lo, hl);
    chk("low_bits_ignored", rdata, 32'h77);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
